ulpi_sniffer_ext: RTL

Parametrised ULPI link-side sniffer/controller for an 8-bit SDR ULPI PHY, all logic in the ULPI_CLK domain. It performs PHY register reads and writes, including extended (8-bit) register addresses. It abort-and-retries register accesses when the PHY takes the bus. Every received byte is tagged as RXCMD or packet data, stamped with a free-running timestamp, optionally de-duplicated, and streamed to a downstream clock-crossing FIFO through a valid/ready port with overflow accounting.

---
 rtl/ulpi_pkg.sv | 32 +++
 rtl/ulpi_rx_capture.sv | 71 +++++++
 rtl/ulpi_sniffer_ext.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// Shared encodings for the ULPI link: FSM states, TXCMD fields and the stream beat payload.
package ulpi_pkg;

  typedef enum logic [8:0] {
    ST_IDLE  = 9'b0_0000_0001,
    ST_TXC   = 9'b0_0000_0010,
    ST_EXA   = 9'b0_0000_0100,
    ST_WD    = 9'b0_0000_1000,
    ST_STP   = 9'b0_0001_0000,
    ST_TA    = 9'b0_0010_0000,
    ST_RD    = 9'b0_0100_0000,
    ST_RX    = 9'b0_1000_0000,
    ST_ERROR = 9'b1_0000_0000
  } ulpi_state_e;

  localparam logic [1:0] TXCMD_REGW    = 2'b10;
  localparam logic [1:0] TXCMD_REGR    = 2'b11;
  localparam logic [5:0] EXT_ADDR      = 6'h2F;
  localparam logic [7:0] NOOP          = 8'h00;
  localparam logic [7:0] EXT_THRESHOLD = 8'h2E;

  typedef struct packed {
    logic       rxcmd;
    logic [7:0] data;
  } rx_beat_t;

  // Register-access command byte; extended accesses carry the escape address.
  function automatic logic [7:0] txcmd(input logic wr, input logic ext, input logic [5:0] addr);
    return {(wr ? TXCMD_REGW : TXCMD_REGR), (ext ? EXT_ADDR : addr)};
  endfunction

endpackage

// File: rtl/ulpi_rx_capture.sv
// Tags received bytes, timestamps them, filters repeated RXCMDs and feeds the
// single-entry output register with drop accounting.
module ulpi_rx_capture
  import ulpi_pkg::*;
#(
  parameter int unsigned TS_WIDTH     = 16,
  parameter int unsigned RXCMD_FILTER = 1
) (
  input  logic                ULPI_CLK,
  input  logic                RST,
  input  logic                cap_en,
  input  logic                cap_nxt,
  input  logic [7:0]          cap_data,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_rxcmd,
  output logic [TS_WIDTH-1:0] out_ts,
  output logic                out_valid,
  output logic [15:0]         drop_count,
  output logic                overflow
);

  logic [TS_WIDTH-1:0] ts_q;
  rx_beat_t            beat_q;
  logic [7:0]          last_rxcmd_q;
  logic                last_vld_q;
  logic                is_rxcmd;
  logic                filtered;
  logic                take;
  logic                can_load;

  assign is_rxcmd = ~cap_nxt;
  assign filtered = (RXCMD_FILTER != 0) && is_rxcmd && last_vld_q && (cap_data == last_rxcmd_q);
  assign take     = cap_en && !filtered;
  assign can_load = !out_valid || out_ready;

  assign out_data  = beat_q.data;
  assign out_rxcmd = beat_q.rxcmd;

  always_ff @(posedge ULPI_CLK) begin
    if (RST) begin
      ts_q         <= '0;
      beat_q       <= '0;
      out_ts       <= '0;
      out_valid    <= 1'b0;
      drop_count   <= 16'h0000;
      overflow     <= 1'b0;
      last_rxcmd_q <= 8'h00;
      last_vld_q   <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
      if (take && can_load) begin
        beat_q    <= '{rxcmd: is_rxcmd, data: cap_data};
        out_ts    <= ts_q;
        out_valid <= 1'b1;
        if (is_rxcmd) begin
          last_rxcmd_q <= cap_data;
          last_vld_q   <= 1'b1;
        end
      end else begin
        if (out_ready) out_valid <= 1'b0;
        // Output still held: the new byte is lost.
        if (take) begin
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ulpi_sniffer_ext.sv
// ULPI link controller: register access FSM with abort/retry, pad registers,
// and the receive capture path.
module ulpi_sniffer_ext
  import ulpi_pkg::*;
#(
  parameter int unsigned TS_WIDTH     = 16,
  parameter int unsigned EXT_REG      = 1,
  parameter int unsigned RXCMD_FILTER = 1
) (
  input  logic                ULPI_CLK,
  input  logic                RST,
  output logic                ULPI_RST_N,
  input  logic                ULPI_DIR,
  input  logic                ULPI_NXT,
  output logic                ULPI_STP,
  input  logic [7:0]          ULPI_D_I,
  output logic [7:0]          ULPI_D_O,
  output logic                ULPI_D_OE,
  input  logic [7:0]          REG_ADDR,
  input  logic [7:0]          REG_DATA_WRITE,
  output logic [7:0]          REG_DATA_READ,
  input  logic                REG_WRITE_REQ,
  output logic                REG_WRITE_ACK,
  input  logic                REG_READ_REQ,
  output logic                REG_READ_ACK,
  output logic [7:0]          REG_RETRIES,
  output logic [7:0]          OUT_DATA,
  output logic                OUT_RXCMD,
  output logic [TS_WIDTH-1:0] OUT_TS,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [15:0]         DROP_COUNT,
  output logic                OVERFLOW
);

  ulpi_state_e state, state_nx;
  logic        op_wr_q, op_wr_nx;
  logic        ext_q, ext_nx;
  logic        dir_q;
  logic [7:0]  d_nx;
  logic        oe_nx, stp_nx;
  logic        wr_pend, rd_pend, ext_addr, abort, cap_en;

  assign ULPI_RST_N = ~RST;
  assign ext_addr   = (EXT_REG != 0) && (REG_ADDR > EXT_THRESHOLD);
  assign wr_pend    = REG_WRITE_REQ && !REG_WRITE_ACK;
  assign rd_pend    = REG_READ_REQ && !REG_READ_ACK;
  assign cap_en     = (state == ST_RX) && ULPI_DIR && dir_q;

  // PHY taking the bus mid-access kills the access; it is reissued from IDLE.
  assign abort = (((state == ST_TXC) || (state == ST_EXA) || (state == ST_WD)) && ULPI_DIR)
              || ((state == ST_TA) && ULPI_DIR && ULPI_NXT);

  // Next-state decode; operation type and address mode are frozen on leaving IDLE.
  always_comb begin
    state_nx = state;
    op_wr_nx = op_wr_q;
    ext_nx   = ext_q;
    case (state)
      ST_IDLE: begin
        op_wr_nx = wr_pend;
        ext_nx   = ext_addr;
        if (ULPI_DIR)                state_nx = ST_RX;
        else if (wr_pend || rd_pend) state_nx = ST_TXC;
      end
      ST_TXC: begin
        if (ULPI_DIR)      state_nx = ST_RX;
        else if (ULPI_NXT) state_nx = ext_q ? ST_EXA : (op_wr_q ? ST_WD : ST_TA);
      end
      ST_EXA: begin
        if (ULPI_DIR)      state_nx = ST_RX;
        else if (ULPI_NXT) state_nx = op_wr_q ? ST_WD : ST_TA;
      end
      ST_WD: begin
        if (ULPI_DIR)      state_nx = ST_RX;
        else if (ULPI_NXT) state_nx = ST_STP;
      end
      ST_STP: state_nx = ST_IDLE;
      ST_TA: begin
        if (ULPI_DIR && ULPI_NXT) state_nx = ST_RX;
        else if (ULPI_DIR)        state_nx = ST_RD;
      end
      ST_RD:   state_nx = ULPI_DIR ? ST_RX : ST_IDLE;
      ST_RX:   state_nx = ULPI_DIR ? ST_RX : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Pad values follow the next state so they land on the bus with it.
  always_comb begin
    d_nx   = NOOP;
    oe_nx  = 1'b0;
    stp_nx = 1'b0;
    case (state_nx)
      ST_IDLE: oe_nx = 1'b1;
      ST_TXC: begin
        oe_nx = 1'b1;
        d_nx  = txcmd(op_wr_nx, ext_nx, REG_ADDR[5:0]);
      end
      ST_EXA: begin
        oe_nx = 1'b1;
        d_nx  = REG_ADDR;
      end
      ST_WD: begin
        oe_nx = 1'b1;
        d_nx  = REG_DATA_WRITE;
      end
      ST_STP: begin
        oe_nx  = 1'b1;
        stp_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ULPI_CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      op_wr_q       <= 1'b0;
      ext_q         <= 1'b0;
      dir_q         <= 1'b0;
      ULPI_D_O      <= NOOP;
      ULPI_D_OE     <= 1'b0;
      ULPI_STP      <= 1'b0;
      REG_WRITE_ACK <= 1'b0;
      REG_READ_ACK  <= 1'b0;
      REG_DATA_READ <= 8'h00;
      REG_RETRIES   <= 8'h00;
    end else begin
      state     <= state_nx;
      op_wr_q   <= op_wr_nx;
      ext_q     <= ext_nx;
      dir_q     <= ULPI_DIR;
      ULPI_D_O  <= d_nx;
      ULPI_D_OE <= oe_nx;
      ULPI_STP  <= stp_nx;
      if (abort && (REG_RETRIES != 8'hFF)) REG_RETRIES <= REG_RETRIES + 8'd1;
      if (state == ST_STP)     REG_WRITE_ACK <= 1'b1;
      else if (!REG_WRITE_REQ) REG_WRITE_ACK <= 1'b0;
      if (state == ST_RD) begin
        REG_DATA_READ <= ULPI_D_I;
        REG_READ_ACK  <= 1'b1;
      end else if (!REG_READ_REQ) begin
        REG_READ_ACK <= 1'b0;
      end
    end
  end

  ulpi_rx_capture #(
    .TS_WIDTH     (TS_WIDTH),
    .RXCMD_FILTER (RXCMD_FILTER)
  ) u_rx_capture (
    .ULPI_CLK   (ULPI_CLK),
    .RST        (RST),
    .cap_en     (cap_en),
    .cap_nxt    (ULPI_NXT),
    .cap_data   (ULPI_D_I),
    .out_ready  (OUT_READY),
    .out_data   (OUT_DATA),
    .out_rxcmd  (OUT_RXCMD),
    .out_ts     (OUT_TS),
    .out_valid  (OUT_VALID),
    .drop_count (DROP_COUNT),
    .overflow   (OVERFLOW)
  );

endmodule
